// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-port arbiter.
//   state_e       - arbiter FSM states
//   SZ_B/H/W      - access size encodings (2'b11 is treated as a word)
//   GNT_CORE/LDR  - grant ids (also the bit index in the arbiter vectors)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RMW  = 2'd2
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_LDR  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clock, reset_n - clock and asynchronous active-low reset
//   req[1:0]       - requests (bit 0 core, bit 1 loader)
//   advance        - a grant is being consumed this cycle; update history
//   gnt[1:0]       - one-hot grant (all zero when nobody asks)
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Id of the requester granted most recently; starts at loader so the core wins the first tie.
    logic last_r;

    // Grant selection: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (last_r == GNT_LDR) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

    // Grant history register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= GNT_LDR;
        end else if (advance && (req != 2'b00)) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the RAM data port between the core LSU (c_*) and the
// program loader (l_*). Word writes complete in the accept cycle; reads return
// data one cycle later; byte/half stores become a read then a merged write.
//   clock, reset_n        - clock, asynchronous active-low reset
//   c_req/we/size/addr/wdata, c_ready, c_rvalid, c_rdata - core port (byte address)
//   l_req/we/addr/wdata,  l_ready, l_rvalid, l_rdata     - loader port (word address)
//   mem_we/addr/wdata, mem_rdata - RAM data port (read data registered in the RAM)
//   busy                  - FSM is not in IDLE
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [1:0]    c_size,
    input  logic [AW+1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_ready,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_ready,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    // Insert right-aligned store data into the selected lane of the old word.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                               input logic [31:0] new_d,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = old_w;
        case (size)
            SZ_B: begin
                case (off)
                    2'd0:    r[7:0]   = new_d[7:0];
                    2'd1:    r[15:8]  = new_d[7:0];
                    2'd2:    r[23:16] = new_d[7:0];
                    2'd3:    r[31:24] = new_d[7:0];
                    default: r        = old_w;
                endcase
            end
            SZ_H: begin
                // Only off[1] picks the half; off[0] is ignored (no misalignment trap).
                if (off[1]) begin
                    r[31:16] = new_d[15:0];
                end else begin
                    r[15:0]  = new_d[15:0];
                end
            end
            default: r = new_d;
        endcase
        return r;
    endfunction

    state_e        state_r, state_nxt_s;
    logic [1:0]    gnt_s;
    logic          idle_s, accept_s, win_ldr_s;
    logic          req_we_s, req_word_s;
    logic [1:0]    req_size_s, req_off_s;
    logic [AW-1:0] req_addr_s;
    logic [31:0]   req_wdata_s;
    logic          gnt_r, we_r;
    logic [1:0]    size_r, off_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r, c_rdata_r, l_rdata_r;

    assign idle_s    = (state_r == IDLE);
    // reset_n gating keeps ready/mem_we low for the whole reset, not just after the state clears.
    assign accept_s  = reset_n & idle_s & (gnt_s != 2'b00);
    assign win_ldr_s = gnt_s[1];
    assign busy      = ~idle_s;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({l_req, c_req}),
        .advance (idle_s),
        .gnt     (gnt_s)
    );

    // Winner's request fields; the loader is always a word access at offset 0.
    always_comb begin
        req_we_s    = c_we;
        req_size_s  = c_size;
        req_addr_s  = c_addr[AW+1:2];
        req_off_s   = c_addr[1:0];
        req_wdata_s = c_wdata;
        if (win_ldr_s) begin
            req_we_s    = l_we;
            req_size_s  = SZ_W;
            req_addr_s  = l_addr;
            req_off_s   = 2'b00;
            req_wdata_s = l_wdata;
        end else begin
            req_we_s    = c_we;
        end
        req_word_s = (req_size_s != SZ_B) && (req_size_s != SZ_H);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and RAM/handshake outputs.
    always_comb begin
        state_nxt_s = state_r;
        mem_we      = 1'b0;
        mem_addr    = addr_r;
        mem_wdata   = wdata_r;
        c_ready     = 1'b0;
        l_ready     = 1'b0;
        c_rvalid    = 1'b0;
        l_rvalid    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    c_ready   = ~win_ldr_s;
                    l_ready   = win_ldr_s;
                    mem_addr  = req_addr_s;
                    mem_wdata = req_wdata_s;
                    if (!req_we_s) begin
                        state_nxt_s = RD;
                    end else if (req_word_s) begin
                        mem_we      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RMW;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD: begin
                c_rvalid    = (gnt_r == GNT_CORE);
                l_rvalid    = (gnt_r == GNT_LDR);
                state_nxt_s = IDLE;
            end
            RMW: begin
                mem_we      = we_r;
                mem_wdata   = merge_lane(mem_rdata, wdata_r, size_r, off_r);
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Capture the accepted request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_r   <= GNT_CORE;
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            off_r   <= 2'b00;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            gnt_r   <= win_ldr_s;
            we_r    <= req_we_s;
            size_r  <= req_size_s;
            off_r   <= req_off_s;
            addr_r  <= req_addr_s;
            wdata_r <= req_wdata_s;
        end else begin
            gnt_r   <= gnt_r;
            we_r    <= we_r;
            size_r  <= size_r;
            off_r   <= off_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Read-data hold registers so rdata keeps its last value between pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_rdata_r <= 32'h0000_0000;
            l_rdata_r <= 32'h0000_0000;
        end else begin
            c_rdata_r <= c_rvalid ? mem_rdata : c_rdata_r;
            l_rdata_r <= l_rvalid ? mem_rdata : l_rdata_r;
        end
    end

    // Read data is passed straight through during the valid pulse.
    always_comb begin
        if (c_rvalid) begin
            c_rdata = mem_rdata;
        end else begin
            c_rdata = c_rdata_r;
        end
        if (l_rvalid) begin
            l_rdata = mem_rdata;
        end else begin
            l_rdata = l_rdata_r;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the data port of the dual-port instruction/data RAM between the core load/store unit (LSU) and the program loader/debug port.
- Arbitrates between the two requesters with round-robin.
- The RAM writes whole words only, so the block turns byte and halfword stores into read-modify-write sequences.
- Sits between the LSU/loader and the RAM's data port (`write_en`, `daddr`, `data_i`, `data_o`). The instruction port is not touched.

## Interface
Parameters:
- `DEPTH`, 1024: RAM depth in 32-bit words. `AW = $clog2(DEPTH)`.
- Data width is fixed at 32. This is not a parameter, because the byte-lane logic depends on it.

Ports:
- `clock`  in  1  the single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  core request. Held with all fields stable until `c_ready`.
- `c_we`  in  1  core request is a write.
- `c_size`  in  2  access size: 00 byte, 01 half, 10 word; 11 behaves as word.
- `c_addr`  in  AW+2  core byte address.
- `c_wdata`  in  32  core store data, right-aligned (byte in [7:0], half in [15:0]).
- `c_ready`  out  1  core request accepted this cycle.
- `c_rvalid`  out  1  core read data valid, one-cycle pulse.
- `c_rdata`  out  32  raw aligned word. The LSU does lane select and extension.
- `l_req`  in  1  loader request (word-only, stable until accepted).
- `l_we`  in  1  loader write.
- `l_addr`  in  AW  loader word address.
- `l_wdata`  in  32  loader write data.
- `l_ready`  out  1  loader request accepted.
- `l_rvalid`  out  1  loader read data valid, one-cycle pulse.
- `l_rdata`  out  32  loader read data.
- `mem_we`  out  1  to RAM `write_en`.
- `mem_addr`  out  AW  to RAM `daddr`.
- `mem_wdata`  out  32  to RAM `data_i`.
- `mem_rdata`  in  32  from RAM `data_o`. Registered: valid the cycle after the address is presented.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, RD, RMW.
- Acceptance:
  - A request is accepted only in IDLE.
  - On acceptance the block asserts `ready` for one cycle and registers grant id, we, size, word address, byte offset and wdata.
- Arbitration:
  - If only one requester asks, it wins.
  - If both ask, the one not granted last wins.
  - `last` is a 1-bit register. It resets to "loader", so the core wins the first tie.
- IDLE, word write accepted: `mem_we=1`, `mem_addr`/`mem_wdata` come from the request inputs in the same cycle. Stay in IDLE.
- IDLE, read accepted: drive `mem_addr`, then go to RD.
- IDLE, sub-word write accepted: drive `mem_addr` for a read, then go to RMW.
- RD: the winner's `rvalid=1`, `rdata=mem_rdata`, then go to IDLE.
- RMW:
  - Merge the registered lane data into `mem_rdata` and drive `mem_we=1` at the registered address, then go to IDLE.
  - Byte lane = `addr[1:0]`.
  - Half lane = `addr[1]`, lower or upper; `addr[0]` is ignored.
  - Word access ignores `addr[1:0]`.
  - No misalignment trap.
- Outside IDLE both `ready` outputs are 0. Requests wait and are not dropped.
- `rdata` holds its last value when `rvalid=0`.
- `mem_addr` is don't-care when no access is in progress; it is driven from the registered address outside IDLE.

## Timing
- Latencies:
  - Word write: 1 cycle; back-to-back at 1 per cycle.
  - Read: `rvalid` arrives 1 cycle after `ready`; throughput 1 per 2 cycles.
  - Sub-word write: the RAM write happens 1 cycle after `ready`; throughput 1 per 2 cycles.
- Reset values (reset asserted):
  - state = IDLE, `last` = loader, captured registers 0.
  - All outputs are 0 (`ready`, `rvalid`, `mem_we`, `busy`, `rdata`); `ready` is forced 0 while `reset_n` is low.
- Reset mid-operation: an RMW or RD in flight is abandoned. No partial write is issued, because `mem_we` drops asynchronously with the state.
- Simultaneous requests: exactly one `ready` per cycle, never both.
- A requester granted in a cycle loses the next tie if the other requester is still waiting.
- The core reading a word written by the loader in the previous cycle sees the new data: the RAM write completes before the read cycle.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE, RD, RMW);
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - grant id constants GNT_CORE, GNT_LDR.
- One sub-module, `rr_arb2`: a two-input round-robin arbiter.
  - Inputs: `req[1:0]`, `advance`. Output: one-hot `gnt[1:0]`.
  - Its `last` register is clocked with the same `clock`/`reset_n`.
- Byte merge is combinational logic in the top module.

## Test plan
- Core word write `addr=0x10`, `wdata=0xDEADBEEF`, then read `0x10`:
  - `mem_we` pulses at word 4 in the accept cycle.
  - `c_rvalid` comes 1 cycle after `c_ready` with `0xDEADBEEF`.
- Byte store `0xAA` to `addr=0x12` over word `0x11223344`:
  - read at word 4, then write `0x11AA3344` the next cycle.
  - `busy` is high for 1 cycle.
- Half store `0xBEEF` to `addr=0x13` over `0x00000000`: `addr[0]` is ignored and the written word is `0xBEEF0000`.
- `c_req` and `l_req` (word reads) held together for 6 cycles: grants alternate core, loader, core. The core goes first after reset and there is never a double `ready`.
- Core word write to `0x20` interleaved with loader word write to word 9 back-to-back: one write per cycle, 2 cycles total, correct addresses.
- `reset_n` low during the RMW cycle of a byte store: `mem_we` stays 0 and the word is unchanged. After release: IDLE, `busy=0`, and the next core request is accepted immediately.
